// File: rtl/collision_ctrl_if.sv
// Bus between the game front end and collision_ctrl: the scan-aligned draw flags go in,
// and the hit, lives and freeze status comes out to the movement logic and the HUD.
interface collision_ctrl_if #(
    parameter int c_NUM_CARS = 4
);
    // There is no valid/ready pair on this bus. The draw flags are sampled on every clock
    // edge. i_Frame_End is a single-cycle pulse that closes the frame. Every o_* signal is
    // registered and changes only on a clock edge.
    logic                  i_Game_Active;
    logic                  i_Frame_End;
    logic                  i_Draw_Frog;
    logic [c_NUM_CARS-1:0] i_Draw_Cars;
    logic                  o_Hit;
    logic [c_NUM_CARS-1:0] o_Hit_Cars;
    logic [3:0]            o_Lives;
    logic                  o_Freeze;
    logic                  o_Game_Over;
    logic [1:0]            o_Dbg_State;

    modport master (
        output i_Game_Active, i_Frame_End, i_Draw_Frog, i_Draw_Cars,
        input  o_Hit, o_Hit_Cars, o_Lives, o_Freeze, o_Game_Over, o_Dbg_State
    );

    modport slave (
        input  i_Game_Active, i_Frame_End, i_Draw_Frog, i_Draw_Cars,
        output o_Hit, o_Hit_Cars, o_Lives, o_Freeze, o_Game_Over, o_Dbg_State
    );
endinterface

// File: rtl/collision_ctrl.sv
// Frog/car overlap detector: accumulates pixel overlap per frame and, at frame end,
// turns it into a life loss followed by either a freeze period or game over.
module collision_ctrl #(
    parameter int c_NUM_CARS      = 4,
    parameter int c_LIVES         = 3,
    parameter int c_FREEZE_FRAMES = 60
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    collision_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FREEZE = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [3:0] LIVES_INIT  = 4'(c_LIVES);
    localparam logic [7:0] FREEZE_INIT = 8'(c_FREEZE_FRAMES);

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [c_NUM_CARS-1:0] mask_q, mask_d;
    logic                  hit_q, hit_d;
    logic [c_NUM_CARS-1:0] hit_cars_q, hit_cars_d;
    logic [3:0]            lives_q, lives_d;
    logic [7:0]            frz_cnt_q, frz_cnt_d;
    logic                  freeze_q, freeze_d;
    logic                  game_over_q, game_over_d;

    // The overlap on the current cycle is folded in before the frame-end decision,
    // so a hit landing on the frame-end cycle still counts for the closing frame.
    logic                  pend_now;
    logic [c_NUM_CARS-1:0] mask_now;

    always_comb begin
        pend_now = pend_q | (bus.i_Draw_Frog & (|bus.i_Draw_Cars));
        mask_now = mask_q | (bus.i_Draw_Cars & {c_NUM_CARS{bus.i_Draw_Frog}});
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        mask_d      = mask_q;
        hit_d       = 1'b0;
        hit_cars_d  = hit_cars_q;
        lives_d     = lives_q;
        frz_cnt_d   = frz_cnt_q;
        freeze_d    = freeze_q;
        game_over_d = game_over_q;

        if (!bus.i_Game_Active) begin
            state_d     = IDLE;
            lives_d     = LIVES_INIT;
            pend_d      = 1'b0;
            mask_d      = '0;
            frz_cnt_d   = '0;
            freeze_d    = 1'b0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = PLAY;
                    lives_d     = LIVES_INIT;
                    pend_d      = 1'b0;
                    mask_d      = '0;
                    freeze_d    = 1'b0;
                    game_over_d = 1'b0;
                end
                PLAY: begin
                    pend_d = pend_now;
                    mask_d = mask_now;
                    if (bus.i_Frame_End) begin
                        pend_d = 1'b0;
                        mask_d = '0;
                        if (pend_now) begin
                            hit_d      = 1'b1;
                            hit_cars_d = mask_now;
                            freeze_d   = 1'b1;
                            // Last life goes straight to OVER and pins lives at zero.
                            if (lives_q <= 4'd1) begin
                                state_d     = OVER;
                                lives_d     = 4'd0;
                                game_over_d = 1'b1;
                            end else begin
                                state_d   = FREEZE;
                                lives_d   = lives_q - 4'd1;
                                frz_cnt_d = FREEZE_INIT;
                            end
                        end
                    end
                end
                FREEZE: begin
                    pend_d   = 1'b0;
                    mask_d   = '0;
                    freeze_d = 1'b1;
                    if (bus.i_Frame_End) begin
                        frz_cnt_d = frz_cnt_q - 8'd1;
                        if (frz_cnt_q <= 8'd1) begin
                            state_d   = PLAY;
                            freeze_d  = 1'b0;
                            frz_cnt_d = '0;
                        end
                    end
                end
                OVER: begin
                    pend_d      = 1'b0;
                    mask_d      = '0;
                    lives_d     = 4'd0;
                    freeze_d    = 1'b1;
                    game_over_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            mask_q      <= '0;
            hit_q       <= 1'b0;
            hit_cars_q  <= '0;
            lives_q     <= LIVES_INIT;
            frz_cnt_q   <= '0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            hit_q       <= hit_d;
            hit_cars_q  <= hit_cars_d;
            lives_q     <= lives_d;
            frz_cnt_q   <= frz_cnt_d;
            freeze_q    <= freeze_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.o_Hit       = hit_q;
    assign bus.o_Hit_Cars  = hit_cars_q;
    assign bus.o_Lives     = lives_q;
    assign bus.o_Freeze    = freeze_q;
    assign bus.o_Game_Over = game_over_q;
    assign bus.o_Dbg_State = state_q;
endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: reset, clean frames, single and multi-car hits,
// frame-end coincident overlap, the freeze length, and running out of lives.
module tb_collision_ctrl;
  localparam int NC = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_FREEZE = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  // clock / reset
  logic i_Clk = 1'b0;
  logic i_Reset;
  always #5 i_Clk = ~i_Clk;

  collision_ctrl_if #(.c_NUM_CARS(NC)) bus ();

  collision_ctrl #(
    .c_NUM_CARS(NC),
    .c_LIVES(3),
    .c_FREEZE_FRAMES(60)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int h0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_lives;
  logic [NC-1:0] car_sel;

  // counts every o_Hit pulse, so extra or missing pulses show up as count errors
  always @(negedge i_Clk) if (bus.o_Hit === 1'b1) hit_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers: apply one cycle of inputs; return 1 time unit after the capturing edge
  task automatic drive(input logic ga, input logic fe, input logic frog, input logic [NC-1:0] cars);
    bus.i_Game_Active = ga;
    bus.i_Frame_End   = fe;
    bus.i_Draw_Frog   = frog;
    bus.i_Draw_Cars   = cars;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic frame(input logic [NC-1:0] cars, input int ovl_px);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, cars);
    for (int p = 0; p < ovl_px; p++) drive(1'b1, 1'b0, 1'b1, cars);
    drive(1'b1, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
  endtask

  // a frame spent frozen: full overlap that must be ignored
  task automatic freeze_frame();
    drive(1'b1, 1'b0, 1'b1, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 4'hF);
  endtask

  initial begin
    bus.i_Game_Active = 1'b0;
    bus.i_Frame_End   = 1'b0;
    bus.i_Draw_Frog   = 1'b0;
    bus.i_Draw_Cars   = '0;
    i_Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    i_Reset = 1'b0;

    check("rst_lives", 32'(bus.o_Lives), 32'd3);
    check("rst_hit", 32'(bus.o_Hit), 32'd0);
    check("rst_hit_cars", 32'(bus.o_Hit_Cars), 32'd0);
    check("rst_freeze", 32'(bus.o_Freeze), 32'd0);
    check("rst_over", 32'(bus.o_Game_Over), 32'd0);
    check("rst_state", 32'(bus.o_Dbg_State), 32'(S_IDLE));

    // five frames where frog and cars are drawn but never on the same pixel
    drive(1'b1, 1'b0, 1'b0, '0);
    check("start_state", 32'(bus.o_Dbg_State), 32'(S_PLAY));
    h0 = hit_cnt;
    for (int f = 0; f < 5; f++) begin
      drive(1'b1, 1'b0, 1'b1, '0);
      drive(1'b1, 1'b0, 1'b1, '0);
      drive(1'b1, 1'b0, 1'b0, 4'hF);
      drive(1'b1, 1'b0, 1'b0, 4'hF);
      drive(1'b1, 1'b1, 1'b0, 4'hA);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    check("clean_hits", 32'(hit_cnt), 32'(h0));
    check("clean_lives", 32'(bus.o_Lives), 32'd3);
    check("clean_freeze", 32'(bus.o_Freeze), 32'd0);

    // car1 overlaps for 10 px
    frame(4'b0010, 10);
    check("car1_hit", 32'(bus.o_Hit), 32'd1);
    check("car1_cars", 32'(bus.o_Hit_Cars), 32'h2);
    check("car1_lives", 32'(bus.o_Lives), 32'd2);
    check("car1_freeze", 32'(bus.o_Freeze), 32'd1);
    check("car1_state", 32'(bus.o_Dbg_State), 32'(S_FREEZE));
    drive(1'b1, 1'b0, 1'b0, '0);
    check("car1_hit_pulse", 32'(bus.o_Hit), 32'd0);
    check("car1_cars_held", 32'(bus.o_Hit_Cars), 32'h2);
    for (int i = 0; i < 59; i++) freeze_frame();
    check("freeze_59", 32'(bus.o_Freeze), 32'd1);
    check("freeze_59_lives", 32'(bus.o_Lives), 32'd2);
    freeze_frame();
    check("freeze_60", 32'(bus.o_Freeze), 32'd0);
    check("freeze_60_state", 32'(bus.o_Dbg_State), 32'(S_PLAY));
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("freeze_no_accum", 32'(hit_cnt), 32'(h0 + 1));
    check("freeze_no_accum_lives", 32'(bus.o_Lives), 32'd2);

    // dropping game_active reloads lives
    drive(1'b0, 1'b0, 1'b0, '0);
    check("inactive_lives", 32'(bus.o_Lives), 32'd3);
    check("inactive_state", 32'(bus.o_Dbg_State), 32'(S_IDLE));

    // overlap only on the frame-end cycle
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 4'b0100);
    check("fe_ovl_hit", 32'(bus.o_Hit), 32'd1);
    check("fe_ovl_lives", 32'(bus.o_Lives), 32'd2);
    check("fe_ovl_cars", 32'(bus.o_Hit_Cars), 32'h4);

    // reset mid-freeze, together with a frame-end overlap
    drive(1'b1, 1'b0, 1'b0, '0);
    i_Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'hF);
    i_Reset = 1'b0;
    check("midrst_state", 32'(bus.o_Dbg_State), 32'(S_IDLE));
    check("midrst_lives", 32'(bus.o_Lives), 32'd3);
    check("midrst_freeze", 32'(bus.o_Freeze), 32'd0);
    check("midrst_hit", 32'(bus.o_Hit), 32'd0);

    // car0 and car3 in one frame
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    h0 = hit_cnt;
    drive(1'b1, 1'b0, 1'b1, 4'b0001);
    drive(1'b1, 1'b0, 1'b1, 4'b0001);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 4'b1000);
    drive(1'b1, 1'b1, 1'b0, '0);
    check("multi_hit", 32'(bus.o_Hit), 32'd1);
    check("multi_cars", 32'(bus.o_Hit_Cars), 32'h9);
    check("multi_lives", 32'(bus.o_Lives), 32'd2);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("multi_single_pulse", 32'(hit_cnt), 32'(h0 + 1));

    // three hits to game over
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    for (int k = 0; k < 3; k++) begin
      car_sel = 4'(1 << k);
      frame(car_sel, 2);
      exp_lives = exp_q.pop_front();
      check("chain_hit", 32'(bus.o_Hit), 32'd1);
      check("chain_lives", 32'(bus.o_Lives), 32'(exp_lives));
      if (k < 2) begin
        for (int i = 0; i < 60; i++) freeze_frame();
        check("chain_unfreeze", 32'(bus.o_Freeze), 32'd0);
      end
    end
    check("over_flag", 32'(bus.o_Game_Over), 32'd1);
    check("over_freeze", 32'(bus.o_Freeze), 32'd1);
    check("over_state", 32'(bus.o_Dbg_State), 32'(S_OVER));
    check("over_cars", 32'(bus.o_Hit_Cars), 32'h4);
    drive(1'b1, 1'b0, 1'b0, '0);
    h0 = hit_cnt;
    for (int i = 0; i < 3; i++) frame(4'hF, 3);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("over_no_hit", 32'(hit_cnt), 32'(h0));
    check("over_lives", 32'(bus.o_Lives), 32'd0);
    check("over_sticky", 32'(bus.o_Game_Over), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0);
    check("restart_lives", 32'(bus.o_Lives), 32'd3);
    check("restart_over", 32'(bus.o_Game_Over), 32'd0);
    check("restart_freeze", 32'(bus.o_Freeze), 32'd0);
    check("restart_state", 32'(bus.o_Dbg_State), 32'(S_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
